// File: rtl/buzzer_sched_pkg.sv
// Shared types and beep pattern constants for the buzzer sequencer.
// Patterns are indexed by source code minus one (key, chime, alarm).
package buzzer_sched_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_KEY   = 2'd1,
        SRC_CHIME = 2'd2,
        SRC_ALARM = 2'd3
    } src_e;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

    localparam int PAT_W = 12;

    typedef struct packed {
        logic [2:0]       beeps;
        logic [PAT_W-1:0] on_t;
        logic [PAT_W-1:0] off_t;
        logic [PAT_W-1:0] gap_t;
    } pattern_t;

    localparam pattern_t [2:0] PATTERNS = '{
        '{beeps: 3'd4, on_t: 12'd100, off_t: 12'd100, gap_t: 12'd500},  // alarm
        '{beeps: 3'd2, on_t: 12'd200, off_t: 12'd100, gap_t: 12'd0},    // chime
        '{beeps: 3'd1, on_t: 12'd30,  off_t: 12'd0,   gap_t: 12'd0}     // key
    };

    localparam int ALARM_TIMEOUT_T = 60000;

    function automatic pattern_t pattern_of(input src_e s);
        logic [1:0] idx;
        idx = 2'(s) - 2'd1;
        if (s == SRC_NONE) return '0;
        return PATTERNS[idx];
    endfunction

    function automatic src_e highest(input logic [2:0] p);
        if (p[2]) return SRC_ALARM;
        if (p[1]) return SRC_CHIME;
        if (p[0]) return SRC_KEY;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/buzzer_sched_tone.sv
// Square-wave generator: toggles every tone_div ACLK cycles while en is high.
// restart or en=0 clears the counter and forces the output low on the same edge.
module buzzer_tone_gen #(
    parameter int TONE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              en,
    input  logic [TONE_W-1:0] tone_div,
    output logic              buzz
);

    logic [TONE_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (restart || !en || tone_div == '0) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (cnt >= tone_div - TONE_W'(1)) begin
            // >= so a shrinking tone_div still wraps at the next compare
            cnt  <= '0;
            buzz <= ~buzz;
        end else begin
            cnt <= cnt + TONE_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_sched.sv
// Fixed-priority buzzer sequencer for alarm / chime / key-click requests.
// Define BUZZER_AUTO_SILENCE_EN to end an unattended alarm after ALARM_TIMEOUT_T ticks.
module buzzer_sched
    import buzzer_sched_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int TONE_W   = 16,
    parameter int PH_W     = 12
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [2:0]        req,
    input  logic              enable,
    input  logic              cancel,
    input  logic [TONE_W-1:0] tone_div,
    output logic              buzz_out,
    output logic              busy,
    output logic [1:0]        active_src,
    output logic              done_pulse
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre;
    logic             tick;

    state_e     state, state_n;
    src_e       src, src_n, hi;
    logic [2:0] pending, pend_n, new_req, beeps, beeps_n;
    logic [PH_W-1:0] ph, ph_n;
    logic       accept, ph_end, fin, grant, done_n, tone_restart, timeout;
    pattern_t   pat, gpat;
    logic [PAT_W-1:0] plen;

    assign tick = (pre == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) pre <= '0;
        else        pre <= tick ? '0 : pre + PRE_W'(1);
    end

`ifdef BUZZER_AUTO_SILENCE_EN
    logic [15:0] al_cnt;
    assign timeout = (src == SRC_ALARM) && (al_cnt == 16'(ALARM_TIMEOUT_T));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                          al_cnt <= '0;
        else if (grant || src_n != SRC_ALARM) al_cnt <= '0;
        else if (tick)                       al_cnt <= al_cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        pat = pattern_of(src);
        unique case (state)
            S_ON:    plen = pat.on_t;
            S_OFF:   plen = pat.off_t;
            S_GAP:   plen = pat.gap_t;
            default: plen = '0;
        endcase
        // zero-length phases (key OFF) pass straight through in one cycle
        ph_end  = (state != S_IDLE) &&
                  ((plen == '0) || (tick && ph == PH_W'(plen) - PH_W'(1)));
        hi      = highest(pending);
        gpat    = pattern_of(hi);
        accept  = enable && !cancel;
        new_req = accept ? (req & {src != SRC_ALARM, 2'b11}) : 3'b000;

        state_n = state;
        src_n   = src;
        beeps_n = beeps;
        ph_n    = tick ? ph + PH_W'(1) : ph;
        pend_n  = pending | new_req;
        done_n  = 1'b0;
        fin     = 1'b0;
        grant   = 1'b0;

        if (!accept) begin
            state_n = S_IDLE;
            src_n   = SRC_NONE;
            beeps_n = '0;
            ph_n    = '0;
            pend_n  = '0;
        end else if (hi > src) begin
            grant = 1'b1;
        end else begin
            if (timeout) begin
                fin = 1'b1;
            end else if (ph_end) begin
                ph_n = '0;
                unique case (state)
                    S_ON: begin
                        state_n = S_OFF;
                        beeps_n = beeps - 3'd1;
                    end
                    S_OFF: begin
                        if (beeps != '0)           state_n = S_ON;
                        else if (src == SRC_ALARM) state_n = S_GAP;
                        else                       fin = 1'b1;
                    end
                    S_GAP: begin
                        state_n = S_ON;
                        beeps_n = pat.beeps;
                    end
                    default: ;
                endcase
            end
            if (fin) begin
                done_n = 1'b1;
                if (hi != SRC_NONE) begin
                    grant = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    src_n   = SRC_NONE;
                    ph_n    = '0;
                end
            end
        end

        if (grant) begin
            state_n = S_ON;
            src_n   = hi;
            ph_n    = '0;
            beeps_n = gpat.beeps;
            pend_n[2'(hi) - 2'd1] = 1'b0;
        end

        tone_restart = (state_n == S_ON) && (state != S_ON || grant);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= S_IDLE;
            src        <= SRC_NONE;
            pending    <= '0;
            beeps      <= '0;
            ph         <= '0;
            busy       <= 1'b0;
            active_src <= 2'd0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            pending    <= pend_n;
            beeps      <= beeps_n;
            ph         <= ph_n;
            busy       <= (state_n != S_IDLE);
            active_src <= 2'(src_n);
            done_pulse <= done_n;
        end
    end

    // Tone driven from next state so buzz_out is low on the same edge ON is left
    buzzer_tone_gen #(.TONE_W(TONE_W)) u_tone (
        .clk      (ACLK),
        .rst      (ARESET),
        .restart  (tone_restart),
        .en       (state_n == S_ON),
        .tone_div (tone_div),
        .buzz     (buzz_out)
    );

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed bench for buzzer_sched with TICK_DIV=10 and tone_div=4.
module tb_buzzer_sched;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        enable = 1'b1;
    logic        cancel = 1'b0;
    logic [15:0] tone_div = 16'd4;
    logic        buzz_out, busy, done_pulse;
    logic [1:0]  active_src;

    int checks = 0;
    int errors = 0;

    buzzer_sched #(.TICK_DIV(10), .TONE_W(16), .PH_W(12)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .req        (req),
        .enable     (enable),
        .cancel     (cancel),
        .tone_div   (tone_div),
        .buzz_out   (buzz_out),
        .busy       (busy),
        .active_src (active_src),
        .done_pulse (done_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // req high for one cycle; returns just after the edge that sampled it
    task automatic pulse_req(input logic [2:0] r);
        req = r;
        step();
        req = 3'b000;
    endtask

    task automatic test_reset();
        logic saw;
        #2 ARESET = 1'b1;
        step();
        checks++;
        if ({buzz_out, busy, active_src, done_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b want 00000", {buzz_out, busy, active_src, done_pulse});
        end
        ARESET = 1'b0;
        step();
        pulse_req(3'b100);
        step();
        checks++;
        if (active_src !== 2'd3) begin
            errors++;
            $display("FAIL alarm_grant active_src got %0d want 3", active_src);
        end
        repeat (6) step();
        checks++;
        if (buzz_out !== 1'b1) begin
            errors++;
            $display("FAIL alarm_tone_high got %b want 1", buzz_out);
        end
        #2 ARESET = 1'b1;
        #1;
        checks++;
        if ({buzz_out, busy, active_src} !== 4'b0) begin
            errors++;
            $display("FAIL reset_async got %b want 0000", {buzz_out, busy, active_src});
        end
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busy || buzz_out) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL reset_quiet got activity want none");
        end
    endtask

    task automatic test_key();
        int ndone, tdone;
        pulse_req(3'b001);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL key_latency1 busy got %b want 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || active_src !== 2'd1) begin
            errors++;
            $display("FAIL key_grant busy/src got %b/%0d want 1/1", busy, active_src);
        end
        repeat (3) step();
        checks++;
        if (buzz_out !== 1'b0) begin
            errors++;
            $display("FAIL key_tone_k3 got %b want 0", buzz_out);
        end
        step();
        checks++;
        if (buzz_out !== 1'b1) begin
            errors++;
            $display("FAIL key_tone_k4 got %b want 1", buzz_out);
        end
        repeat (4) step();
        checks++;
        if (buzz_out !== 1'b0) begin
            errors++;
            $display("FAIL key_tone_k8 got %b want 0", buzz_out);
        end
        ndone = 0;
        tdone = -1;
        for (int i = 9; i <= 400; i++) begin
            step();
            if (done_pulse) begin
                ndone++;
                if (tdone < 0) tdone = i;
            end
        end
        checks++;
        if (ndone != 1 || tdone < 290 || tdone > 303) begin
            errors++;
            $display("FAIL key_done count/time got %0d/%0d want 1/290..303", ndone, tdone);
        end
        checks++;
        if (busy !== 1'b0 || buzz_out !== 1'b0) begin
            errors++;
            $display("FAIL key_end busy/buzz got %b/%b want 0/0", busy, buzz_out);
        end
    endtask

    task automatic test_preempt();
        logic saw_done, saw_chime;
        pulse_req(3'b010);
        step();
        checks++;
        if (active_src !== 2'd2) begin
            errors++;
            $display("FAIL pre_chime_grant got %0d want 2", active_src);
        end
        repeat (50) step();
        pulse_req(3'b100);
        step();
        checks++;
        if (active_src !== 2'd3) begin
            errors++;
            $display("FAIL pre_alarm_src got %0d want 3", active_src);
        end
        saw_done  = 1'b0;
        saw_chime = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (done_pulse) saw_done = 1'b1;
            if (active_src != 2'd3) saw_chime = 1'b1;
        end
        checks++;
        if (saw_done || saw_chime) begin
            errors++;
            $display("FAIL pre_no_resume done/other got %b/%b want 0/0", saw_done, saw_chime);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_cancel busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] prev;
        int cnt, tdone, nbeep, last_tog;
        logic prev_buzz;
        pulse_req(3'b010);
        step();
        cnt = 0;
        repeat (50) begin step(); cnt++; end
        pulse_req(3'b001);
        cnt++;
        tdone = -1;
        nbeep = 0;
        last_tog = -1000;
        prev_buzz = buzz_out;
        prev = active_src;
        for (int i = 0; i < 7000 && tdone < 0; i++) begin
            prev = active_src;
            step();
            cnt++;
            if (buzz_out != prev_buzz) begin
                if (cnt - last_tog > 20) nbeep++;
                last_tog = cnt;
            end
            prev_buzz = buzz_out;
            if (done_pulse) tdone = cnt;
        end
        checks++;
        if (tdone < 5980 || tdone > 6010) begin
            errors++;
            $display("FAIL b2b_chime_done time got %0d want 5980..6010", tdone);
        end
        checks++;
        if (prev !== 2'd2 || active_src !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff prev/src/busy got %0d/%0d/%b want 2/1/1", prev, active_src, busy);
        end
        checks++;
        if (nbeep != 2) begin
            errors++;
            $display("FAIL b2b_chime_beeps got %0d want 2", nbeep);
        end
        repeat (400) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_key_end busy got %b want 0", busy);
        end
    endtask

    task automatic test_cancel();
        logic saw;
        pulse_req(3'b100);
        step();
        repeat (3) step();
        cancel = 1'b1;
        req = 3'b010;
        step();
        cancel = 1'b0;
        req = 3'b000;
        checks++;
        if ({buzz_out, busy, active_src} !== 4'b0) begin
            errors++;
            $display("FAIL cancel_idle got %b want 0000", {buzz_out, busy, active_src});
        end
        saw = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (busy || done_pulse) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL cancel_dropped got activity want none");
        end
    endtask

    task automatic test_disable();
        logic saw;
        int ndone;
        enable = 1'b0;
        pulse_req(3'b111);
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL disable_ignore got busy want idle");
        end
        enable = 1'b1;
        step();
        pulse_req(3'b001);
        step();
        repeat (10) step();
        enable = 1'b0;
        step();
        checks++;
        if ({buzz_out, busy, active_src} !== 4'b0) begin
            errors++;
            $display("FAIL disable_abort got %b want 0000", {buzz_out, busy, active_src});
        end
        enable = 1'b1;
        tone_div = 16'd0;
        step();
        pulse_req(3'b001);
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL silent_grant busy got %b want 1", busy);
        end
        saw = 1'b0;
        ndone = 0;
        for (int i = 0; i < 320; i++) begin
            step();
            if (buzz_out) saw = 1'b1;
            if (done_pulse) ndone++;
        end
        checks++;
        if (saw || ndone != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL silent_tone buzz/done/busy got %b/%0d/%b want 0/1/0", saw, ndone, busy);
        end
        tone_div = 16'd4;
    endtask

    initial begin
        test_reset();
        test_key();
        test_preempt();
        test_back_to_back();
        test_cancel();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
